// File: rtl/sprite_blitter_if.sv
// Draw-engine bus: register-file controls, sprite ROM read port and frame-buffer write port.
// The slave modport is the blitter's view; master is the surrounding system / bench.
interface sprite_blitter_if #(
  parameter int ID_W   = 5,
  parameter int ROM_AW = 15,
  parameter int PIX_W  = 16,
  parameter int ADDR_W = 20
) ();
  logic              start;
  logic [ID_W-1:0]   img_id;
  logic [9:0]        img_x;
  logic [9:0]        img_y;
  logic              frame_sel;
  logic              done;
  logic [ROM_AW-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_ack;

  modport slave (
    input  start, img_id, img_x, img_y, frame_sel, rom_data, wr_ack,
    output done, rom_addr, wr_req, wr_addr, wr_data
  );

  modport master (
    output start, img_id, img_x, img_y, frame_sel, rom_data, wr_ack,
    input  done, rom_addr, wr_req, wr_addr, wr_data
  );
endinterface

// File: rtl/sprite_blitter.sv
// Copies one IMG_W x IMG_H sprite from a sync ROM into the frame buffer with colour-key
// transparency and per-pixel clipping; 2 cycles per skipped pixel, 2 + ack wait per written one.
module sprite_blitter #(
  parameter int          IMG_W    = 32,
  parameter int          IMG_H    = 32,
  parameter int          ID_W     = 5,
  parameter int          SCREEN_W = 640,
  parameter int          SCREEN_H = 480,
  parameter int          PIX_W    = 16,
  parameter int          ADDR_W   = 20,
  parameter logic [15:0] TRANSP   = 16'h0000
) (
  input logic            i_clk,
  input logic            i_rst,
  sprite_blitter_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [10:0]       SW11  = 11'(SCREEN_W);
  localparam logic [10:0]       SH11  = 11'(SCREEN_H);
  localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(SCREEN_W * SCREEN_H);
  localparam logic [PIX_W-1:0]  KEY   = PIX_W'(TRANSP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ID_W-1:0]   r_id;
  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic              r_fsel;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [PIX_W-1:0]  r_wr_data;

  logic [10:0]       w_x;
  logic [10:0]       w_y;
  logic              w_vis;
  logic              w_col_last;
  logic              w_last_pix;
  logic              w_advance;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_pix_addr;

  // 11-bit sums so that imgX/imgY near 1023 plus an offset cannot wrap back on-screen
  assign w_x        = {1'b0, r_x} + 11'(r_col);
  assign w_y        = {1'b0, r_y} + 11'(r_row);
  assign w_vis      = (bus.rom_data != KEY) && (w_x < SW11) && (w_y < SH11);
  assign w_col_last = (r_col == CW'(IMG_W - 1));
  assign w_last_pix = w_col_last && (r_row == RW'(IMG_H - 1));
  assign w_advance  = ((r_state == S_WAIT) && !w_vis) || ((r_state == S_WRITE) && bus.wr_ack);
  assign w_base     = r_fsel ? BASE1 : '0;
  assign w_pix_addr = w_base + ADDR_W'(w_y) * ADDR_W'(SCREEN_W) + ADDR_W'(w_x);

  assign bus.rom_addr = {r_id, r_row, r_col};
  assign bus.wr_req   = (r_state == S_WRITE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_FETCH;
      S_FETCH: w_next = S_WAIT;
      S_WAIT: begin
        if (w_vis)           w_next = S_WRITE;
        else if (w_last_pix) w_next = S_DONE;
        else                 w_next = S_FETCH;
      end
      S_WRITE: begin
        if (bus.wr_ack) w_next = w_last_pix ? S_DONE : S_FETCH;
      end
      S_DONE:  if (!bus.start) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_id      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_fsel    <= 1'b0;
      r_row     <= '0;
      r_col     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      if ((r_state == S_IDLE) && bus.start) begin
        r_id   <= bus.img_id;
        r_x    <= bus.img_x;
        r_y    <= bus.img_y;
        r_fsel <= bus.frame_sel;
        r_row  <= '0;
        r_col  <= '0;
      end else if (w_advance) begin
        r_col <= r_col + 1'b1;
        if (w_col_last) r_row <= r_row + 1'b1;
      end
      if ((r_state == S_WAIT) && w_vis) begin
        r_wr_addr <= w_pix_addr;
        r_wr_data <= bus.rom_data;
      end
    end
  end
endmodule
